// File: rtl/lutram_arbiter.sv
// lutram_arbiter: shares the write port and the read port of a simple-dual-port,
// read-first distributed RAM between two clients each. Memory controls are
// registered, read responses are routed back through a latency-matched tag
// pipeline, and out-of-range requests are rejected and counted.
module lutram_arbiter #(
    parameter int unsigned DEPTH  = 8000,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 200,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w0_valid,
    output logic              w0_ready,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_valid,
    output logic              w1_ready,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr,
    output logic              mem_ena,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    output logic              mem_enb,
    output logic [ADDR_W-1:0] mem_addrb,
    input  logic [DATA_W-1:0] mem_doutb,
    output logic [15:0]       err_cnt
);

    typedef enum logic {CL0 = 1'b0, CL1 = 1'b1} client_e;

    typedef struct packed {
        logic    vld;
        client_e id;
        logic    err;
    } tag_t;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    client_e           wptr;
    client_e           rptr;
    logic              w_acc;
    logic              r_acc;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_oor;
    logic              r_oor;
    client_e           r_sel;
    tag_t              tag_in;
    tag_t              rtag;
    tag_t [RD_LAT:0]   tags;
    logic [1:0]        err_inc;
    logic [16:0]       err_sum;

    // Round-robin grants: a lone requester wins, a tie goes to the pointer; held low in reset
    always_comb begin
        w0_ready = 1'b0;
        w1_ready = 1'b0;
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (rst) begin
            w0_ready = w0_valid && (!w1_valid || wptr == CL0);
            w1_ready = w1_valid && (!w0_valid || wptr == CL1);
            r0_ready = r0_valid && (!r1_valid || rptr == CL0);
            r1_ready = r1_valid && (!r0_valid || rptr == CL1);
        end
    end

    assign w_acc  = w0_ready || w1_ready;
    assign r_acc  = r0_ready || r1_ready;
    assign w_addr = w1_ready ? w1_addr : w0_addr;
    assign w_data = w1_ready ? w1_data : w0_data;
    assign r_addr = r1_ready ? r1_addr : r0_addr;
    assign r_sel  = r1_ready ? CL1 : CL0;
    assign w_oor  = ({1'b0, w_addr} >= LIMIT);
    assign r_oor  = ({1'b0, r_addr} >= LIMIT);
    assign tag_in = tag_t'{vld: r_acc, id: r_sel, err: r_acc && r_oor};

    // Priority pointers move to the client that lost each grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= CL0;
            rptr <= CL0;
        end else begin
            if (w_acc) wptr <= w1_ready ? CL0 : CL1;
            if (r_acc) rptr <= r1_ready ? CL0 : CL1;
        end
    end

    // Registered write port; out-of-range writes are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_ena   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
        end else begin
            mem_ena <= w_acc && !w_oor;
            mem_we  <= w_acc && !w_oor;
            if (w_acc && !w_oor) begin
                mem_addra <= w_addr;
                mem_dina  <= w_data;
            end
        end
    end

    // Registered read port plus tag pipeline; error reads still occupy a slot to keep order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_enb   <= 1'b0;
            mem_addrb <= '0;
            tags      <= '0;
        end else begin
            mem_enb <= r_acc && !r_oor;
            if (r_acc && !r_oor) mem_addrb <= r_addr;
            tags <= {tags[RD_LAT-1:0], tag_in};
        end
    end

    assign err_inc = {1'b0, w_acc && w_oor} + {1'b0, r_acc && r_oor};
    assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};

    // Saturating count of rejected requests
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_cnt <= '0;
        else      err_cnt <= err_sum[16] ? '1 : err_sum[15:0];
    end

    assign rtag = tags[RD_LAT];

    // Response routing from the oldest tag; rdata is a plain mux of the memory output
    always_comb begin
        r0_rvalid = rtag.vld && (rtag.id == CL0);
        r1_rvalid = rtag.vld && (rtag.id == CL1);
        rerr      = rtag.vld && rtag.err;
        rdata     = (rtag.vld && !rtag.err) ? mem_doutb : '0;
    end

endmodule

// File: tb/tb_lutram_arbiter.sv
// tb_lutram_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model (arbitration rule, storage map, response queue).
module tb_lutram_arbiter;

    localparam int DEPTH = 8000;
    localparam int AW    = 13;
    localparam int DW    = 200;

    logic          clk;
    logic          rst;
    logic          w0_valid, w1_valid, r0_valid, r1_valid;
    logic          w0_ready, w1_ready, r0_ready, r1_ready;
    logic [AW-1:0] w0_addr, w1_addr, r0_addr, r1_addr;
    logic [DW-1:0] w0_data, w1_data;
    logic          r0_rvalid, r1_rvalid, rerr;
    logic [DW-1:0] rdata;
    logic          mem_ena, mem_we, mem_enb;
    logic [AW-1:0] mem_addra, mem_addrb;
    logic [DW-1:0] mem_dina, mem_doutb;
    logic [15:0]   err_cnt;

    logic [DW-1:0] tbmem [0:DEPTH-1];
    logic [DW-1:0] q1, q2;
    logic          mem_clr;

    int n_cmp;
    int n_fail;

    typedef struct {
        int            due;
        int            cl;
        bit            err;
        logic [DW-1:0] data;
    } resp_t;

    logic [DW-1:0] ref_mem [int];

    lutram_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid), .rdata(rdata), .rerr(rerr),
        .mem_ena(mem_ena), .mem_we(mem_we), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM with two-cycle read latency
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) tbmem[i] <= '0;
        end else if (mem_ena && mem_we && mem_addra < AW'(DEPTH)) begin
            tbmem[mem_addra] <= mem_dina;
        end
        if (mem_enb && mem_addrb < AW'(DEPTH)) q1 <= tbmem[mem_addrb];
        q2 <= q1;
    end
    assign mem_doutb = q2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w0_valid = 1'b0;
        w1_valid = 1'b0;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 70) return AW'($urandom_range(0, 15));
        else if (r < 85) return AW'($urandom_range(7990, 7999));
        else return AW'($urandom_range(8000, 8191));
    endfunction

    // Round-robin rule: lone requester wins, both requesting -> the priority client
    function automatic int pick(logic v0, logic v1, int ptr);
        if (v0 && v1) return ptr;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic test_reset();
        logic [9:0] flags;
        rst = 1'b0;
        w0_valid = 1'b1; w1_valid = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            flags = {w0_ready, w1_ready, r0_ready, r1_ready, r0_rvalid, r1_rvalid, rerr, mem_ena, mem_we, mem_enb};
            n_cmp++;
            if (flags !== '0) begin
                n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000000", flags);
            end
            n_cmp++;
            if (mem_addra !== '0 || mem_addrb !== '0 || mem_dina !== '0 || rdata !== '0 || err_cnt !== '0) begin
                n_fail++;
                $display("FAIL reset_data: got addra=%h addrb=%h dina=%h rdata=%h err_cnt=%h expected all 0",
                         mem_addra, mem_addrb, mem_dina, rdata, err_cnt);
            end
            step();
        end
        idle();
    endtask

    task automatic test_write_arb();
        logic [DW-1:0] a, b;
        logic [1:0] exp_g;
        a = rand_data();
        b = rand_data();
        apply_reset();
        w0_valid = 1'b1; w0_addr = 13'd5; w0_data = a;
        w1_valid = 1'b1; w1_addr = 13'd6; w1_data = b;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) idle();
            #1;
            if (i < 4) begin
                exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
                n_cmp++;
                if ({w0_ready, w1_ready} !== exp_g) begin
                    n_fail++; $display("FAIL warb_grant[%0d]: got %b expected %b", i, {w0_ready, w1_ready}, exp_g);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if (mem_we !== 1'b1 || mem_ena !== 1'b1 || mem_addra !== ((i % 2 == 1) ? 13'd5 : 13'd6)
                    || mem_dina !== ((i % 2 == 1) ? a : b)) begin
                    n_fail++;
                    $display("FAIL warb_memwr[%0d]: got we=%b addra=%0d expected we=1 addra=%0d",
                             i, mem_we, mem_addra, (i % 2 == 1) ? 5 : 6);
                end
            end
            step();
        end
    endtask

    task automatic test_read_rt();
        logic [2:0] exp_rsp;
        apply_reset();
        w0_valid = 1'b1; w0_addr = 13'd100; w0_data = 200'h3;
        step();
        idle();
        step();
        r1_valid = 1'b1; r1_addr = 13'd100;
        #1;
        n_cmp++;
        if (r1_ready !== 1'b1) begin
            n_fail++; $display("FAIL rt_grant: got %b expected 1", r1_ready);
        end
        step();
        idle();
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (k == 1) begin
                n_cmp++;
                if (mem_enb !== 1'b1 || mem_addrb !== 13'd100) begin
                    n_fail++; $display("FAIL rt_enb: got enb=%b addrb=%0d expected enb=1 addrb=100", mem_enb, mem_addrb);
                end
            end
            exp_rsp = (k == 3) ? 3'b010 : 3'b000;
            n_cmp++;
            if ({r0_rvalid, r1_rvalid, rerr} !== exp_rsp) begin
                n_fail++; $display("FAIL rt_rsp[%0d]: got %b expected %b", k, {r0_rvalid, r1_rvalid, rerr}, exp_rsp);
            end
            if (k == 3) begin
                n_cmp++;
                if (rdata !== 200'h3) begin
                    n_fail++; $display("FAIL rt_data: got %h expected 3", rdata);
                end
            end
            step();
        end
    endtask

    task automatic test_interleave();
        logic [DW-1:0] x, y, exp_d;
        logic [2:0] exp_rsp;
        x = rand_data();
        y = rand_data();
        apply_reset();
        w0_valid = 1'b1; w0_addr = 13'd1; w0_data = x;
        step();
        w0_addr = 13'd2; w0_data = y;
        step();
        idle();
        step();
        r0_valid = 1'b1; r0_addr = 13'd1;
        r1_valid = 1'b1; r1_addr = 13'd2;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) idle();
            #1;
            if (k < 2) begin
                n_cmp++;
                if ({r0_ready, r1_ready} !== ((k == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL il_grant[%0d]: got %b expected %b", k, {r0_ready, r1_ready}, (k == 0) ? 2'b10 : 2'b01);
                end
            end
            exp_rsp = (k == 3) ? 3'b100 : (k == 4) ? 3'b010 : 3'b000;
            n_cmp++;
            if ({r0_rvalid, r1_rvalid, rerr} !== exp_rsp) begin
                n_fail++; $display("FAIL il_rsp[%0d]: got %b expected %b", k, {r0_rvalid, r1_rvalid, rerr}, exp_rsp);
            end
            if (k == 3 || k == 4) begin
                exp_d = (k == 3) ? x : y;
                n_cmp++;
                if (rdata !== exp_d) begin
                    n_fail++; $display("FAIL il_data[%0d]: got %h expected %h", k, rdata, exp_d);
                end
            end
            step();
        end
    endtask

    task automatic test_oor();
        logic [2:0]  exp_rsp;
        logic [15:0] exp_cnt;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k == 0) begin w0_valid = 1'b1; w0_addr = 13'd8000; w0_data = rand_data(); end
            if (k == 1) begin r0_valid = 1'b1; r0_addr = 13'd8191; end
            #1;
            if (k == 0) begin
                n_cmp++;
                if (w0_ready !== 1'b1) begin n_fail++; $display("FAIL oor_wgrant: got %b expected 1", w0_ready); end
            end
            if (k == 1) begin
                n_cmp++;
                if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL oor_rgrant: got %b expected 1", r0_ready); end
            end
            if (k >= 1) begin
                n_cmp++;
                if ({mem_ena, mem_we, mem_enb} !== 3'b000) begin
                    n_fail++; $display("FAIL oor_mem[%0d]: got ena/we/enb=%b expected 000", k, {mem_ena, mem_we, mem_enb});
                end
            end
            exp_cnt = (k == 0) ? 16'd0 : (k == 1) ? 16'd1 : 16'd2;
            n_cmp++;
            if (err_cnt !== exp_cnt) begin
                n_fail++; $display("FAIL oor_cnt[%0d]: got %0d expected %0d", k, err_cnt, exp_cnt);
            end
            exp_rsp = (k == 4) ? 3'b101 : 3'b000;
            n_cmp++;
            if ({r0_rvalid, r1_rvalid, rerr} !== exp_rsp) begin
                n_fail++; $display("FAIL oor_rsp[%0d]: got %b expected %b", k, {r0_rvalid, r1_rvalid, rerr}, exp_rsp);
            end
            if (k == 4) begin
                n_cmp++;
                if (rdata !== '0) begin n_fail++; $display("FAIL oor_data: got %h expected 0", rdata); end
            end
            step();
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d_old, d_new, exp_d;
        logic [2:0] exp_rsp;
        d_old = rand_data();
        d_new = rand_data();
        apply_reset();
        w0_valid = 1'b1; w0_addr = 13'd7; w0_data = d_old;
        step();
        idle();
        step();
        step();
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k == 0) begin
                w0_valid = 1'b1; w0_addr = 13'd7; w0_data = d_new;
                r0_valid = 1'b1; r0_addr = 13'd7;
            end
            if (k == 1) begin r1_valid = 1'b1; r1_addr = 13'd7; end
            #1;
            if (k == 0) begin
                n_cmp++;
                if ({w0_ready, r0_ready} !== 2'b11) begin
                    n_fail++; $display("FAIL col_grant: got %b expected 11", {w0_ready, r0_ready});
                end
            end
            exp_rsp = (k == 3) ? 3'b100 : (k == 4) ? 3'b010 : 3'b000;
            n_cmp++;
            if ({r0_rvalid, r1_rvalid, rerr} !== exp_rsp) begin
                n_fail++; $display("FAIL col_rsp[%0d]: got %b expected %b", k, {r0_rvalid, r1_rvalid, rerr}, exp_rsp);
            end
            if (k == 3 || k == 4) begin
                exp_d = (k == 3) ? d_old : d_new;
                n_cmp++;
                if (rdata !== exp_d) begin
                    n_fail++; $display("FAIL col_data[%0d]: got %h expected %h", k, rdata, exp_d);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        logic [9:0] flags;
        logic [2:0] exp_rsp;
        apply_reset();
        w0_valid = 1'b1; w0_addr = 13'd9; w0_data = rand_data();
        r0_valid = 1'b1; r0_addr = 13'd100;
        step();
        idle();
        n_cmp++;
        if (mem_enb !== 1'b1 || mem_addra !== 13'd9) begin
            n_fail++; $display("FAIL mf_pre: got enb=%b addra=%0d expected enb=1 addra=9", mem_enb, mem_addra);
        end
        rst = 1'b0;
        w0_valid = 1'b1; w1_valid = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            flags = {w0_ready, w1_ready, r0_ready, r1_ready, r0_rvalid, r1_rvalid, rerr, mem_ena, mem_we, mem_enb};
            n_cmp++;
            if (flags !== '0 || mem_addra !== '0 || mem_addrb !== '0 || mem_dina !== '0 || rdata !== '0 || err_cnt !== '0) begin
                n_fail++;
                $display("FAIL mf_inreset[%0d]: got flags=%b addra=%h addrb=%h err_cnt=%h expected all 0",
                         k, flags, mem_addra, mem_addrb, err_cnt);
            end
            step();
        end
        rst = 1'b1;
        w0_addr = 13'd11; w0_data = rand_data();
        r0_addr = 13'd100;
        #1;
        n_cmp++;
        if ({w0_ready, w1_ready, r0_ready, r1_ready} !== 4'b1010) begin
            n_fail++; $display("FAIL mf_grant: got %b expected 1010", {w0_ready, w1_ready, r0_ready, r1_ready});
        end
        for (int k = 4; k <= 8; k++) begin
            if (k > 4) #1;
            exp_rsp = (k == 7) ? 3'b100 : 3'b000;
            n_cmp++;
            if ({r0_rvalid, r1_rvalid, rerr} !== exp_rsp) begin
                n_fail++; $display("FAIL mf_rsp[%0d]: got %b expected %b", k, {r0_rvalid, r1_rvalid, rerr}, exp_rsp);
            end
            if (k == 7) begin
                n_cmp++;
                if (rdata !== 200'h3) begin n_fail++; $display("FAIL mf_data: got %h expected 3", rdata); end
            end
            step();
            idle();
        end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_cnt;
        apply_reset();
        w0_valid = 1'b1; w0_addr = 13'd8000;
        r0_valid = 1'b1; r0_addr = 13'd8191;
        for (int n = 1; n <= 32769; n++) begin
            step();
            if (n == 1 || n >= 32767) begin
                exp_cnt = (n == 1) ? 16'd2 : (n == 32767) ? 16'hFFFE : 16'hFFFF;
                n_cmp++;
                if (err_cnt !== exp_cnt) begin
                    n_fail++; $display("FAIL sat_cnt[%0d]: got %h expected %h", n, err_cnt, exp_cnt);
                end
            end
        end
        idle();
    endtask

    task automatic test_random();
        int            gw, gr, wptr_m, rptr_m, nerr, exp_err;
        bit            exp_we, exp_enb;
        logic [AW-1:0] exp_addra, exp_addrb, a;
        logic [DW-1:0] exp_dina, exp_rd, d;
        logic [3:0]    exp_rdy;
        logic [2:0]    exp_rsp;
        resp_t         r;
        resp_t         rq[$];
        apply_reset();
        mem_clr = 1'b1;
        step();
        mem_clr = 1'b0;
        ref_mem.delete();
        wptr_m = 0; rptr_m = 0; exp_err = 0; exp_we = 1'b0; exp_enb = 1'b0;
        exp_addra = '0; exp_addrb = '0; exp_dina = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400) begin
                w0_valid = 1'($urandom_range(0, 1)); w0_addr = rand_addr(); w0_data = rand_data();
                w1_valid = 1'($urandom_range(0, 1)); w1_addr = rand_addr(); w1_data = rand_data();
                r0_valid = 1'($urandom_range(0, 1)); r0_addr = rand_addr();
                r1_valid = 1'($urandom_range(0, 1)); r1_addr = rand_addr();
            end else begin
                idle();
            end
            #1;
            gw = pick(w0_valid, w1_valid, wptr_m);
            gr = pick(r0_valid, r1_valid, rptr_m);
            exp_rdy = {gw == 0, gw == 1, gr == 0, gr == 1};
            n_cmp++;
            if ({w0_ready, w1_ready, r0_ready, r1_ready} !== exp_rdy) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, {w0_ready, w1_ready, r0_ready, r1_ready}, exp_rdy);
            end
            n_cmp++;
            if ({mem_ena, mem_we} !== {exp_we, exp_we} || (exp_we && (mem_addra !== exp_addra || mem_dina !== exp_dina))) begin
                n_fail++; $display("FAIL rnd_wport[%0d]: got we=%b addra=%0d expected we=%b addra=%0d", cyc, mem_we, mem_addra, exp_we, exp_addra);
            end
            n_cmp++;
            if (mem_enb !== exp_enb || (exp_enb && mem_addrb !== exp_addrb)) begin
                n_fail++; $display("FAIL rnd_rport[%0d]: got enb=%b addrb=%0d expected enb=%b addrb=%0d", cyc, mem_enb, mem_addrb, exp_enb, exp_addrb);
            end
            n_cmp++;
            if (err_cnt !== 16'(exp_err)) begin
                n_fail++; $display("FAIL rnd_errcnt[%0d]: got %0d expected %0d", cyc, err_cnt, exp_err);
            end
            exp_rsp = 3'b000;
            exp_rd  = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                exp_rsp = {r.cl == 0, r.cl == 1, r.err};
                exp_rd  = r.err ? '0 : r.data;
            end
            n_cmp++;
            if ({r0_rvalid, r1_rvalid, rerr} !== exp_rsp || (exp_rsp[2:1] != 2'b00 && rdata !== exp_rd)) begin
                n_fail++; $display("FAIL rnd_rsp[%0d]: got %b data=%h expected %b data=%h", cyc, {r0_rvalid, r1_rvalid, rerr}, rdata, exp_rsp, exp_rd);
            end
            // Reads see storage before this cycle's write (read-first collision)
            nerr = 0; exp_we = 1'b0; exp_enb = 1'b0;
            if (gr >= 0) begin
                a = (gr == 1) ? r1_addr : r0_addr;
                if (a < DEPTH) begin
                    d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
                    rq.push_back('{cyc + 3, gr, 1'b0, d});
                    exp_enb = 1'b1; exp_addrb = a;
                end else begin
                    rq.push_back('{cyc + 3, gr, 1'b1, '0});
                    nerr++;
                end
                rptr_m = 1 - gr;
            end
            if (gw >= 0) begin
                a = (gw == 1) ? w1_addr : w0_addr;
                d = (gw == 1) ? w1_data : w0_data;
                if (a < DEPTH) begin
                    ref_mem[int'(a)] = d;
                    exp_we = 1'b1; exp_addra = a; exp_dina = d;
                end else begin
                    nerr++;
                end
                wptr_m = 1 - gw;
            end
            exp_err = (exp_err + nerr > 65535) ? 65535 : exp_err + nerr;
            step();
        end
        n_cmp++;
        if (rq.size() != 0) begin
            n_fail++; $display("FAIL rnd_drain: got %0d responses outstanding expected 0", rq.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        mem_clr = 1'b0;
        rst = 1'b1;
        idle();
        w0_addr = '0; w1_addr = '0; r0_addr = '0; r1_addr = '0;
        w0_data = '0; w1_data = '0;
        #2;
        test_reset();
        test_write_arb();
        test_read_rt();
        test_interleave();
        test_oor();
        test_collision();
        test_reset_midflight();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
